// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per clock on operand magnitudes, with sign fix-up on completion.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] tag_out,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    op_t                op_q, op_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [TAG_W-1:0]   tag_out_q, tag_out_d;

    // Request decode: signedness, magnitudes and the two shortcut cases.
    op_t              op_in;
    logic             a_signed, b_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             div_by_zero, div_overflow;

    always_comb begin
        op_in        = op_t'(op);
        a_signed     = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                       (op_in == OP_DIV)  || (op_in == OP_REM);
        b_signed     = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
        a_neg        = a_signed && a[WIDTH-1];
        b_neg        = b_signed && b[WIDTH-1];
        a_mag        = a_neg ? -a : a;
        b_mag        = b_neg ? -b : b;
        div_by_zero  = op_in[2] && (b == '0);
        div_overflow = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                       (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    end

    // One iteration of each algorithm; hi/lo hold {product} or {remainder, quotient}.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_nx, mul_lo_nx;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_hi_nx, div_lo_nx;
    logic [2*WIDTH-1:0] prod_nx, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, final_res;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_hi_nx = mul_sum[WIDTH:1];
        mul_lo_nx = {mul_sum[0], lo_q[WIDTH-1:1]};

        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_hi_nx = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
        div_lo_nx = {lo_q[WIDTH-2:0], div_ge};

        prod_nx   = {mul_hi_nx, mul_lo_nx};
        prod_fix  = neg_q ? -prod_nx : prod_nx;
        quo_fix   = neg_q ? -div_lo_nx : div_lo_nx;
        rem_fix   = neg_q ? -div_hi_nx : div_hi_nx;

        if (op_q[2]) begin
            final_res = op_q[1] ? rem_fix : quo_fix;
        end else begin
            final_res = (op_q == OP_MUL) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a latch.
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        neg_d     = neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opnd_d    = opnd_q;
        tag_d     = tag_q;
        result_d  = result_q;
        tag_out_d = tag_out_q;

        unique case (state_q)
            S_IDLE: begin
                count_d = '0;
                if (in_valid && !flush) begin
                    op_d   = op_in;
                    tag_d  = tag_in;
                    // REM follows the dividend's sign; everything else the xor of both.
                    neg_d  = (op_in[2] && op_in[1]) ? a_neg : (a_neg ^ b_neg);
                    hi_d   = '0;
                    lo_d   = op_in[2] ? a_mag : b_mag;
                    opnd_d = op_in[2] ? b_mag : a_mag;
                    if (div_by_zero) begin
                        result_d  = op_in[1] ? a : '1;
                        tag_out_d = tag_in;
                        state_d   = S_DONE;
                    end else if (div_overflow) begin
                        result_d  = op_in[1] ? '0 : a;
                        tag_out_d = tag_in;
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                hi_d    = op_q[2] ? div_hi_nx : mul_hi_nx;
                lo_d    = op_q[2] ? div_lo_nx : mul_lo_nx;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    result_d  = final_res;
                    tag_out_d = tag_q;
                    count_d   = '0;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d = S_IDLE;
            count_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            op_q      <= OP_MUL;
            neg_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            tag_q     <= '0;
            result_q  <= '0;
            tag_out_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opnd_q    <= opnd_d;
            tag_q     <= tag_d;
            result_q  <= result_d;
            tag_out_q <= tag_out_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;
    assign tag_out   = tag_out_q;

endmodule
